// File: rtl/ex_mem_branch_stage_pkg.sv
// Shared pipeline widths and the EX/MEM control bundle for the word-addressed pipeline.
package ex_mem_branch_stage_pkg;

    localparam int unsigned PIPE_ADDR_W = 32;
    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned DATA_W      = 32;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ex_mem_ctrl_t;

    // A squashed or bubble slot must never carry live side-effecting control.
    function automatic ex_mem_ctrl_t gate_ctrl(input ex_mem_ctrl_t ctrl, input logic valid);
        ex_mem_ctrl_t res;
        res.mem_read   = ctrl.mem_read   & valid;
        res.mem_write  = ctrl.mem_write  & valid;
        res.reg_write  = ctrl.reg_write  & valid;
        res.mem_to_reg = ctrl.mem_to_reg & valid;
        return res;
    endfunction

endpackage

// File: rtl/ex_mem_branch_stage_if.sv
// EX-side inputs and EX/MEM register outputs of the branch stage, bundled as one interface.
interface ex_mem_branch_stage_if
    import ex_mem_branch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = PIPE_ADDR_W
);
    logic                 stall;
    logic                 flush;
    logic                 in_valid;
    logic [ADDR_W-1:0]    pc_next;
    logic [DATA_W-1:0]    shift_imm;
    logic [DATA_W-1:0]    alu_result;
    logic                 alu_zero;
    logic [DATA_W-1:0]    rt_data;
    logic [REG_IDX_W-1:0] write_reg;
    logic                 branch_eq;
    logic                 branch_ne;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 mem_to_reg;

    logic                 out_valid;
    logic [ADDR_W-1:0]    branch_target;
    logic                 pcsrc;
    logic                 squash_upstream;
    logic [DATA_W-1:0]    alu_result_q;
    logic [DATA_W-1:0]    rt_data_q;
    logic [REG_IDX_W-1:0] write_reg_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic                 reg_write_q;
    logic                 mem_to_reg_q;

    modport master (
        output stall, flush, in_valid, pc_next, shift_imm, alu_result, alu_zero,
               rt_data, write_reg, branch_eq, branch_ne,
               mem_read, mem_write, reg_write, mem_to_reg,
        input  out_valid, branch_target, pcsrc, squash_upstream, alu_result_q,
               rt_data_q, write_reg_q, mem_read_q, mem_write_q, reg_write_q, mem_to_reg_q
    );

    modport slave (
        input  stall, flush, in_valid, pc_next, shift_imm, alu_result, alu_zero,
               rt_data, write_reg, branch_eq, branch_ne,
               mem_read, mem_write, reg_write, mem_to_reg,
        output out_valid, branch_target, pcsrc, squash_upstream, alu_result_q,
               rt_data_q, write_reg_q, mem_read_q, mem_write_q, reg_write_q, mem_to_reg_q
    );

endinterface

// File: rtl/ex_mem_branch_stage_branch_squash_ctr.sv
// Stretches a one-cycle taken-branch pulse into a SQUASH_CYCLES-long kill of IF/ID/EX.
module branch_squash_ctr #(
    parameter int unsigned SQUASH_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pcsrc_i,
    input  logic stall_i,
    output logic squash_upstream_o
);

    localparam logic [2:0] RELOAD = 3'(SQUASH_CYCLES - 1);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // The pcsrc cycle itself is the first squash cycle, so the counter covers the remainder.
    always_comb begin
        cnt_d = cnt_q;
        if (pcsrc_i) begin
            cnt_d = RELOAD;
        end else if ((cnt_q != 3'd0) && !stall_i) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign squash_upstream_o = pcsrc_i | (cnt_q != 3'd0);

endmodule

// File: rtl/ex_mem_branch_stage.sv
// EX-stage branch resolution and EX/MEM pipeline register with multi-cycle upstream squash.
module ex_mem_branch_stage
    import ex_mem_branch_stage_pkg::*;
#(
    parameter int unsigned SQUASH_CYCLES = 3,
    parameter int unsigned ADDR_W        = PIPE_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    ex_mem_branch_stage_if.slave bus
);

    logic                 squash;
    logic                 eff_valid;
    logic                 taken_c;
    logic [ADDR_W-1:0]    target_c;
    ex_mem_ctrl_t         ctrl_in;

    logic                 valid_q,  valid_d;
    logic                 pcsrc_q,  pcsrc_d;
    logic [ADDR_W-1:0]    target_q, target_d;
    logic [DATA_W-1:0]    alu_q,    alu_d;
    logic [DATA_W-1:0]    rt_q,     rt_d;
    logic [REG_IDX_W-1:0] wr_q,     wr_d;
    ex_mem_ctrl_t         ctrl_q,   ctrl_d;

    // The EX instruction is younger than any branch already in MEM, so squash kills it here.
    always_comb begin
        eff_valid = bus.in_valid & ~squash;
        target_c  = bus.pc_next + bus.shift_imm[ADDR_W-1:0];
        taken_c   = eff_valid & ((bus.branch_eq & bus.alu_zero) |
                                 (bus.branch_ne & ~bus.alu_zero));
        ctrl_in.mem_read   = bus.mem_read;
        ctrl_in.mem_write  = bus.mem_write;
        ctrl_in.reg_write  = bus.reg_write;
        ctrl_in.mem_to_reg = bus.mem_to_reg;
    end

    // Flush beats stall; pcsrc is a pulse and is cleared on anything but a fresh load.
    always_comb begin
        valid_d  = valid_q;
        pcsrc_d  = 1'b0;
        target_d = target_q;
        alu_d    = alu_q;
        rt_d     = rt_q;
        wr_d     = wr_q;
        ctrl_d   = ctrl_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!bus.stall) begin
            valid_d  = eff_valid;
            pcsrc_d  = taken_c;
            target_d = target_c;
            alu_d    = bus.alu_result;
            rt_d     = bus.rt_data;
            wr_d     = bus.write_reg;
            ctrl_d   = gate_ctrl(ctrl_in, eff_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            pcsrc_q  <= 1'b0;
            target_q <= '0;
            alu_q    <= '0;
            rt_q     <= '0;
            wr_q     <= '0;
            ctrl_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            pcsrc_q  <= pcsrc_d;
            target_q <= target_d;
            alu_q    <= alu_d;
            rt_q     <= rt_d;
            wr_q     <= wr_d;
            ctrl_q   <= ctrl_d;
        end
    end

    branch_squash_ctr #(
        .SQUASH_CYCLES(SQUASH_CYCLES)
    ) u_squash (
        .clk              (clk),
        .reset            (reset),
        .pcsrc_i          (pcsrc_q),
        .stall_i          (bus.stall),
        .squash_upstream_o(squash)
    );

    assign bus.out_valid       = valid_q;
    assign bus.pcsrc           = pcsrc_q;
    assign bus.branch_target   = target_q;
    assign bus.squash_upstream = squash;
    assign bus.alu_result_q    = alu_q;
    assign bus.rt_data_q       = rt_q;
    assign bus.write_reg_q     = wr_q;
    assign bus.mem_read_q      = ctrl_q.mem_read;
    assign bus.mem_write_q     = ctrl_q.mem_write;
    assign bus.reg_write_q     = ctrl_q.reg_write;
    assign bus.mem_to_reg_q    = ctrl_q.mem_to_reg;

endmodule
